// File: rtl/regfile_access_sequencer.sv
// Sequences READ / WRITE_IMM / MOVE commands from two round-robin arbitrated
// requesters onto the save/load ports of the 6-entry, 8-bit register file.
module regfile_access_sequencer #(
  parameter int unsigned NUM_REGS = 6
) (
  input  logic       clock,
  input  logic       reset,

  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [1:0] req0_op,
  input  logic [2:0] req0_src,
  input  logic [2:0] req0_dst,
  input  logic [7:0] req0_imm,

  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [1:0] req1_op,
  input  logic [2:0] req1_src,
  input  logic [2:0] req1_dst,
  input  logic [7:0] req1_imm,

  output logic       rf_save,
  output logic [2:0] rf_saveselector,
  output logic [7:0] rf_savebus,
  output logic [2:0] rf_loadselector,
  input  logic [7:0] rf_loadbus,

  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RSP  = 2'd3;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRIMM = 2'd1;
  localparam logic [1:0] OP_MOVE  = 2'd2;

  logic [1:0] state_q;
  logic       last_q;
  logic [1:0] op_q;
  logic [2:0] src_q;
  logic [2:0] dst_q;
  logic [7:0] imm_q;
  logic       id_q;
  logic       err_q;
  logic [7:0] data_q;
  logic [7:0] rsp_data_q;
  logic       rsp_id_q;

  logic       gnt;
  logic       accept;
  logic [1:0] c_op;
  logic [2:0] c_src;
  logic [2:0] c_dst;
  logic [7:0] c_imm;
  logic       c_err;

  function automatic logic idx_bad(input logic [2:0] idx);
    return {29'd0, idx} >= NUM_REGS;
  endfunction

  always_comb begin
    gnt = 1'b0;
    if (req0_valid && req1_valid)
      gnt = ~last_q;
    else if (req1_valid)
      gnt = 1'b1;
  end

  // Ready is gated by reset so no handshake is ever seen while reset is held.
  assign accept     = reset && (state_q == S_IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !gnt;
  assign req1_ready = accept && gnt;

  always_comb begin
    c_op  = gnt ? req1_op  : req0_op;
    c_src = gnt ? req1_src : req0_src;
    c_dst = gnt ? req1_dst : req0_dst;
    c_imm = gnt ? req1_imm : req0_imm;
    c_err = 1'b0;
    case (c_op)
      OP_READ:  c_err = idx_bad(c_src);
      OP_WRIMM: c_err = idx_bad(c_dst);
      OP_MOVE:  c_err = idx_bad(c_src) || idx_bad(c_dst);
      default:  c_err = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;
      op_q       <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      imm_q      <= '0;
      id_q       <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q   <= c_op;
            src_q  <= c_src;
            dst_q  <= c_dst;
            imm_q  <= c_imm;
            id_q   <= gnt;
            err_q  <= c_err;
            last_q <= gnt;
            if (c_err) begin
              data_q  <= '0;
              state_q <= S_RSP;
            end else if (c_op == OP_WRIMM) begin
              state_q <= S_WR;
            end else begin
              state_q <= S_RD;
            end
          end
        end
        S_RD: begin
          data_q  <= rf_loadbus;
          state_q <= (op_q == OP_MOVE) ? S_WR : S_RSP;
        end
        S_WR: begin
          if (op_q == OP_WRIMM)
            data_q <= imm_q;
          state_q <= S_RSP;
        end
        default: begin
          rsp_data_q <= data_q;
          rsp_id_q   <= id_q;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rf_loadselector = (state_q == S_RD) ? src_q : '0;
    rf_save         = (state_q == S_WR);
    rf_saveselector = (state_q == S_WR) ? dst_q : '0;
    rf_savebus      = '0;
    if (state_q == S_WR)
      rf_savebus = (op_q == OP_WRIMM) ? imm_q : data_q;
  end

  // Response fields are live in RSP and otherwise hold the last response.
  assign rsp_valid = (state_q == S_RSP);
  assign rsp_err   = (state_q == S_RSP) && err_q;
  assign rsp_data  = (state_q == S_RSP) ? data_q : rsp_data_q;
  assign rsp_id    = (state_q == S_RSP) ? id_q : rsp_id_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/regfile_access_sequencer.md
# regfile_access_sequencer

Sequences all accesses to the 6-entry, 8-bit register file on behalf of two requesters: port 0 (instruction decode) and port 1 (debug/monitor). Each accepted command becomes a fixed multi-cycle sequence on the register file's save/load ports: read, write-immediate or register-to-register move. A round-robin arbiter shares the register file between the two ports. The block sits between the control unit and the register file and is the only driver of the register file's save, saveselector, savebus and loadselector inputs.

## Interface
- NUM_REGS, 6: number of implemented registers. Indices at or above NUM_REGS are invalid.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low. 0 = reset asserted. The top level inverts this signal for the register file's active-high reset.
- reqN_valid  in  1  command valid on port N (N = 0, 1).
- reqN_ready  out  1  port N command accepted this cycle when reqN_valid=1.
- reqN_op  in  2  00 READ, 01 WRITE_IMM, 10 MOVE, 11 reserved.
- reqN_src  in  3  source register index (READ, MOVE).
- reqN_dst  in  3  destination register index (WRITE_IMM, MOVE).
- reqN_imm  in  8  immediate value for WRITE_IMM.
- rf_save  out  1  register file write enable.
- rf_saveselector  out  3  register file write index.
- rf_savebus  out  8  register file write data.
- rf_loadselector  out  3  register file read index.
- rf_loadbus  in  8  register file read data (combinational in loadselector).
- rsp_valid  out  1  single-cycle completion pulse.
- rsp_id  out  1  port that issued the completing command.
- rsp_data  out  8  READ/MOVE: value read; WRITE_IMM: value written; error: 0x00.
- rsp_err  out  1  command rejected (reserved op or invalid index).
- busy  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, RD, WR, RSP.
- **IDLE**
  - reqN_ready is combinational: 1 only in IDLE, and only for the granted port.
  - If exactly one port is valid, that port is granted.
  - If both ports are valid, the port that was not granted last is granted. The last-grant register resets to 1, so port 0 wins the first tie.
  - On handshake, latch the op, src, dst, imm and id.
- **Validation at accept**
  - The command is an error if op=11, or if a used index is ≥ NUM_REGS (src for READ/MOVE, dst for WRITE_IMM/MOVE).
  - An error command goes IDLE→RSP with rsp_err=1 and rsp_data=0x00.
  - An error command never asserts rf_save.
- **Valid command paths**
  - READ: IDLE→RD→RSP.
  - WRITE_IMM: IDLE→WR→RSP.
  - MOVE: IDLE→RD→WR→RSP.
- **RD:** rf_loadselector = latched src; capture rf_loadbus into data_q at the end of the cycle.
- **WR**
  - rf_save=1, rf_saveselector = latched dst.
  - rf_savebus = imm for WRITE_IMM, data_q for MOVE.
  - For WRITE_IMM, data_q is loaded with imm.
- **RSP:** rsp_valid=1, rsp_id, rsp_data=data_q, rsp_err; always returns to IDLE.
- **Idle output values**
  - Outside RD, rf_loadselector=0.
  - Outside WR: rf_save=0, rf_saveselector=0, rf_savebus=0.
  - Outside RSP: rsp_valid=0, rsp_err=0.
  - rsp_data and rsp_id hold their last values.
- MOVE with src==dst is legal and rewrites the same value.
- A requester must hold its command stable while valid=1 and ready=0. The command is sampled only at the handshake.

## Timing
- **Reset values:** state=IDLE; last-grant=1; data_q=0. All outputs are 0: reqN_ready=0 during reset, rf_*, rsp_*, busy.
- **Reset mid-operation**
  - Asynchronous abort to IDLE; rf_save deasserts immediately, with no partial write beyond edges already taken.
  - No rsp_valid is produced for the aborted command.
- **Latency from handshake in cycle N**
  - READ: RD in N+1, rsp_valid in N+2.
  - WRITE_IMM: WR in N+1 (register updates at the end of N+1), rsp_valid in N+2.
  - MOVE: RD in N+1, WR in N+2, rsp_valid in N+3.
  - Error: rsp_valid in N+1.
- **Throughput:** the next handshake is possible in the cycle after RSP. Back-to-back READs run at 3 cycles per command.
- **Read-after-write:** a READ accepted after a WRITE's RSP sees the new value.
- busy=1 in every cycle from N+1 through the RSP cycle.

## Test plan
- **Reset then read:** reset=0 for 3 cycles, then 1. Port 0 READ src=3 → ready in the handshake cycle; rsp_valid 2 cycles later with rsp_data=0x00, rsp_id=0, rsp_err=0.
- **Write then read:** port 1 WRITE_IMM dst=4 imm=0xA5 → rf_save=1, saveselector=4, savebus=0xA5 for exactly one cycle, and rsp_data=0xA5. A following READ src=4 returns 0xA5.
- **MOVE:** preload reg1=0x3C, then MOVE src=1 dst=5 → RD with loadselector=1, then WR with savebus=0x3C, saveselector=5. rsp_valid at N+3 with rsp_data=0x3C.
- **Arbitration:** hold both ports valid with READs continuously for 6 commands → grants alternate 0,1,0,1,0,1. A single valid port is granted every time.
- **Errors:**
  - op=11 → rsp_err=1 at N+1, rf_save never asserted.
  - WRITE_IMM dst=6 → rsp_err=1, no write.
  - READ src=7 → rsp_err=1, rsp_data=0x00.
- **Reset mid-MOVE:** assert reset during the WR cycle → rf_save drops without waiting for a clock edge, and no rsp_valid appears. After release, state is IDLE and port 0 wins the first tie.
